// File: rtl/rx_descrambler_stream.sv
// Frame receiver/descrambler: valid/ready beats in, LFSR-descrambled beats out through a
// one-deep output register. Per-frame length, mode and seed are latched on start.
module rx_descrambler_stream #(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = 7,
   parameter logic [LFSR_W-1:0] POLY   = 7'h48,
   parameter int                LEN_W  = 12,
   parameter logic [LFSR_W-1:0] SEED   = 7'h7F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              mode,
   input  logic [LFSR_W-1:0] seed,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  beat_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} stateT;

   stateT             state;
   logic [LEN_W-1:0]  lenQ;
   logic              modeQ;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsrNext;
   logic [DATA_W-1:0] descData;
   logic              fb;
   logic              drainOk;
   logic              accept;

   assign drainOk  = !out_valid || out_ready;
   assign in_ready = (state == RUN) && (beat_cnt < lenQ) && drainOk;
   assign accept   = in_valid && in_ready;

   // Whole beat is descrambled bit-serially in one cycle, bit 0 first.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      lfsrNext = lfsr;
      descData = '0;
      fb       = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         // NOTE: blocking assignments here are deliberate -- each bit must see the LFSR
         // already shifted by the previous bit within the same cycle.
         fb          = ^(lfsrNext & POLY);
         descData[i] = in_data[i] ^ fb;
         lfsrNext    = {lfsrNext[LFSR_W-2:0], (modeQ ? in_data[i] : fb)};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         lenQ     <= '0;
         modeQ    <= 1'b0;
         lfsr     <= SEED;
         beat_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  lenQ     <= len;
                  modeQ    <= mode;
                  lfsr     <= seed;
                  beat_cnt <= '0;
               end
            end
            LOAD: begin
               if (lenQ != '0) begin
                  state <= RUN;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + LEN_W'(1);
                  lfsr     <= lfsrNext;
               end
               // Leave only once the last beat has left (or is leaving) the output register.
               if (beat_cnt == lenQ && drainOk) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= descData;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_descrambler_stream.sv
// Directed bench for rx_descrambler_stream: reference scrambler feeds known plaintext,
// outputs are collected by a monitor and compared against that plaintext.
module tb_rx_descrambler_stream;

   localparam int LEN_W = 12;

   logic             clk = 1'b0;
   logic             reset, start, mode, in_valid, out_ready;
   logic [LEN_W-1:0] len;
   logic [6:0]       seed;
   logic [7:0]       in_data;
   logic             in_ready, out_valid, busy, done;
   logic [7:0]       out_data;
   logic [LEN_W-1:0] beat_cnt;

   int testsRun  = 0;
   int failCount = 0;

   logic [7:0]       outQ[$];
   int               doneCycles  = 0;
   int               inReadyCnt  = 0;
   int               outValidCnt = 0;
   logic [LEN_W-1:0] doneBeatCnt = '0;

   logic [7:0] plain   [0:15];
   logic [7:0] txBeats [0:15];
   logic [6:0] txLfsr;
   int q0, d0, ir0, ov0;

   rx_descrambler_stream dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode), .seed(seed),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid && out_ready) outQ.push_back(out_data);
      if (done) begin
         doneCycles++;
         doneBeatCnt = beat_cnt;
      end
      if (in_ready)  inReadyCnt++;
      if (out_valid) outValidCnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference scrambler, taps x^7 + x^4 + 1 written out explicitly.
   task automatic scrambleBeat(input logic [7:0] p, input bit selfSync, output logic [7:0] s);
      logic f;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         f      = txLfsr[6] ^ txLfsr[3];
         s[i]   = p[i] ^ f;
         txLfsr = {txLfsr[5:0], (selfSync ? s[i] : f)};
      end
   endtask

   task automatic makeFrame(input int n, input bit selfSync, input logic [6:0] txSeed);
      txLfsr = txSeed;
      for (int k = 0; k < n; k++) begin
         plain[k] = 8'($urandom);
         scrambleBeat(plain[k], selfSync, txBeats[k]);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic startFrame(input int l, input bit m, input logic [6:0] sd);
      q0  = outQ.size();
      d0  = doneCycles;
      ir0 = inReadyCnt;
      ov0 = outValidCnt;
      tick();
      start = 1'b1;
      len   = l[LEN_W-1:0];
      mode  = m;
      seed  = sd;
      tick();
      start = 1'b0;
   endtask

   task automatic sendBeats(input int n, input int stallAt);
      int w;
      for (int k = 0; k < n; k++) begin
         in_data  = txBeats[k];
         in_valid = 1'b1;
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!in_ready && w < 50);
         if (!in_ready) begin
            check("acceptTimeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
         tick();
         if (k == stallAt) begin
            out_ready = 1'b0;
            if (k + 1 < n) in_data = txBeats[k+1];
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check("stallInReady", 32'(in_ready), 32'd0);
               check("stallValid", 32'(out_valid), 32'd1);
               check("stallData", 32'(out_data), 32'(plain[k]));
            end
            tick();
            out_ready = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic waitDone(input int n, input string tag);
      int w;
      w = 0;
      while (doneCycles == d0 && w < 300) begin
         @(negedge clk);
         #1;
         w++;
      end
      check({tag, "_doneSeen"}, 32'(doneCycles != d0), 32'd1);
      repeat (3) tick();
      check({tag, "_donePulse1"}, 32'(doneCycles - d0), 32'd1);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_beatCount"}, 32'(outQ.size() - q0), 32'(n));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; len = '0; seed = '0;
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;

      // Reset state, with a beat offered to show in_ready stays low
      repeat (3) tick();
      @(negedge clk);
      check("rst_inReady", 32'(in_ready), 32'd0);
      check("rst_outValid", 32'(out_valid), 32'd0);
      check("rst_outData", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_beatCnt", 32'(beat_cnt), 32'd0);
      tick();
      reset = 1'b0;
      in_valid = 1'b0;

      // 1: additive, seed 7F, single zero beat -> 8'h70, done one cycle after output
      startFrame(1, 1'b0, 7'h7F);
      in_data = 8'h00; in_valid = 1'b1;
      @(negedge clk);
      check("t1_loadNoReady", 32'(in_ready), 32'd0);
      check("t1_loadBusy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t1_runReady", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("t1_outValid", 32'(out_valid), 32'd1);
      check("t1_outData", 32'(out_data), 32'h70);
      check("t1_doneEarly", 32'(done), 32'd0);
      check("t1_beatCnt", 32'(beat_cnt), 32'd1);
      @(negedge clk);
      check("t1_done", 32'(done), 32'd1);
      check("t1_outDrained", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("t1_doneCleared", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // 2: additive, 16 beats from the reference scrambler
      makeFrame(16, 1'b0, 7'h7F);
      startFrame(16, 1'b0, 7'h7F);
      sendBeats(16, -1);
      waitDone(16, "t2");
      check("t2_beatCntAtDone", 32'(doneBeatCnt), 32'd16);
      for (int k = 0; k < 16; k++)
         if (outQ.size() > q0 + k)
            check($sformatf("t2_beat%0d", k), 32'(outQ[q0+k]), 32'(plain[k]));

      // 3: self-sync, tx seed 55, rx seed 00 -> beats 2..4 recovered
      makeFrame(4, 1'b1, 7'h55);
      startFrame(4, 1'b1, 7'h00);
      sendBeats(4, -1);
      waitDone(4, "t3");
      for (int k = 1; k < 4; k++)
         if (outQ.size() > q0 + k)
            check($sformatf("t3_beat%0d", k), 32'(outQ[q0+k]), 32'(plain[k]));

      // 4: downstream stall of 3 cycles after the third beat
      makeFrame(8, 1'b0, 7'h7F);
      startFrame(8, 1'b0, 7'h7F);
      sendBeats(8, 2);
      waitDone(8, "t4");
      check("t4_beatCntAtDone", 32'(doneBeatCnt), 32'd8);
      for (int k = 0; k < 8; k++)
         if (outQ.size() > q0 + k)
            check($sformatf("t4_beat%0d", k), 32'(outQ[q0+k]), 32'(plain[k]));

      // 5: empty frame goes LOAD -> DONE without ever accepting
      startFrame(0, 1'b0, 7'h7F);
      in_valid = 1'b1;
      @(negedge clk);
      check("t5_loadBusy", 32'(busy), 32'd1);
      check("t5_loadNoDone", 32'(done), 32'd0);
      @(negedge clk);
      check("t5_done", 32'(done), 32'd1);
      @(negedge clk);
      check("t5_idle", 32'(busy), 32'd0);
      in_valid = 1'b0;
      check("t5_neverReady", 32'(inReadyCnt - ir0), 32'd0);
      check("t5_neverValid", 32'(outValidCnt - ov0), 32'd0);

      // 6: reset after 5 of 10 beats, then a clean 2-beat frame
      makeFrame(10, 1'b0, 7'h7F);
      startFrame(10, 1'b0, 7'h7F);
      sendBeats(5, -1);
      in_valid = 1'b1;
      in_data  = txBeats[5];
      reset    = 1'b1;
      tick();
      @(negedge clk);
      check("t6_rstBusy", 32'(busy), 32'd0);
      check("t6_rstOutValid", 32'(out_valid), 32'd0);
      check("t6_rstBeatCnt", 32'(beat_cnt), 32'd0);
      check("t6_rstInReady", 32'(in_ready), 32'd0);
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      makeFrame(2, 1'b0, 7'h7F);
      startFrame(2, 1'b0, 7'h7F);
      sendBeats(2, -1);
      waitDone(2, "t6");
      check("t6_beatCntAtDone", 32'(doneBeatCnt), 32'd2);
      for (int k = 0; k < 2; k++)
         if (outQ.size() > q0 + k)
            check($sformatf("t6_beat%0d", k), 32'(outQ[q0+k]), 32'(plain[k]));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
